// File: rtl/data_mem.sv
// Data-side memory map for the 16-bit CPU: RAM, screen buffer with scan-out port, keyboard register.
// Define DATA_MEM_KBD_FIFO_EN for a KBD_DEPTH-entry keyboard FIFO; otherwise a single holding register.
module data_mem #(
  parameter int RAM_WORDS = 16384,
  parameter int SCR_WORDS = 8192,
  parameter int KBD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addrM,
  input  logic [15:0] outM,
  input  logic        wrtM,
  output logic [15:0] inM,
  input  logic [15:0] key_code,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [12:0] disp_addr,
  output logic [15:0] disp_data,
  output logic        addr_err
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCR_WORDS);
  localparam logic [15:0] KBD_ADDR = 16'h6000;

  if (KBD_DEPTH < 2 || (KBD_DEPTH & (KBD_DEPTH - 1)) != 0) begin : g_bad_kbd_depth
    $error("KBD_DEPTH must be a power of two and at least 2");
  end

  logic [15:0] r_ram [RAM_WORDS];
  logic [15:0] r_scr [SCR_WORDS];
  logic [15:0] r_disp;
  logic        r_addr_err;

  logic        w_sel_ram;
  logic        w_sel_scr;
  logic        w_sel_kbd;
  logic        w_unmapped;
  logic        w_push;
  logic        w_pop;
  logic        w_kbd_empty;
  logic [15:0] w_kbd_head;

  assign w_sel_ram  = (addrM[15:14] == 2'b00);
  assign w_sel_scr  = (addrM[15:13] == 3'b010);
  assign w_sel_kbd  = (addrM == KBD_ADDR);
  assign w_unmapped = (addrM > KBD_ADDR);

  assign w_push = key_valid && key_ready;
  assign w_pop  = wrtM && w_sel_kbd && !w_kbd_empty;

  always_ff @(posedge clk) begin
    if (wrtM && w_sel_ram) r_ram[addrM[RAM_AW-1:0]] <= outM;
    if (wrtM && w_sel_scr) r_scr[addrM[SCR_AW-1:0]] <= outM;
  end

  // Scan-out reads the pre-write word when the CPU hits the same address.
  always_ff @(posedge clk) begin
    if (reset) r_disp <= 16'h0000;
    else       r_disp <= r_scr[disp_addr[SCR_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset)           r_addr_err <= 1'b0;
    else if (w_unmapped) r_addr_err <= 1'b1;
  end

`ifdef DATA_MEM_KBD_FIFO_EN
  localparam int PTR_W = $clog2(KBD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [15:0]      r_fifo [KBD_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= key_code;
  end

  // Pointers wrap naturally because KBD_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign key_ready   = (r_count != CNT_W'(KBD_DEPTH));
  assign w_kbd_empty = (r_count == '0);
  assign w_kbd_head  = r_fifo[r_rd_ptr];
`else
  logic [15:0] r_hold;
  logic        r_hold_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold       <= 16'h0000;
      r_hold_valid <= 1'b0;
    end else if (w_push) begin
      r_hold       <= key_code;
      r_hold_valid <= 1'b1;
    end else if (w_pop) begin
      r_hold_valid <= 1'b0;
    end
  end

  assign key_ready   = !r_hold_valid;
  assign w_kbd_empty = !r_hold_valid;
  assign w_kbd_head  = r_hold;
`endif

  always_comb begin
    inM = 16'h0000;
    if (w_sel_ram)                      inM = r_ram[addrM[RAM_AW-1:0]];
    else if (w_sel_scr)                 inM = r_scr[addrM[SCR_AW-1:0]];
    else if (w_sel_kbd && !w_kbd_empty) inM = w_kbd_head;
  end

  assign disp_data = r_disp;
  assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed memory-map scenarios, then random traffic against a queue/array model.
module tb_data_mem;

`ifdef DATA_MEM_KBD_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addrM;
  logic [15:0] outM;
  logic        wrtM;
  logic [15:0] inM;
  logic [15:0] key_code;
  logic        key_valid;
  logic        key_ready;
  logic [12:0] disp_addr;
  logic [15:0] disp_data;
  logic        addr_err;

  always #5 clk = ~clk;

  data_mem dut (
    .clk       (clk),
    .reset     (reset),
    .addrM     (addrM),
    .outM      (outM),
    .wrtM      (wrtM),
    .inM       (inM),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .addr_err  (addr_err)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] m_ram   [16384];
  bit          m_ram_v [16384];
  logic [15:0] m_scr   [8192];
  bit          m_scr_v [8192];
  logic [15:0] m_kbd [$];
  bit          m_err;
  logic [15:0] m_disp;
  bit          m_disp_v = 1'b0;
  bit          m_known  = 1'b0;
  logic [12:0] da_cur   = '0;
  logic [15:0] rd;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, check combinational and registered outputs, then advance the model.
  task automatic step(input bit rst, input logic [15:0] a, input logic [15:0] d, input bit w,
                      input bit kv, input logic [15:0] kc, input logic [12:0] da,
                      output logic [15:0] rd_o);
    logic [15:0] exp;
    bit          known;
    bit          do_push;
    bit          do_pop;
    reset = rst; addrM = a; outM = d; wrtM = w; key_valid = kv; key_code = kc; disp_addr = da;
    #1;
    rd_o  = inM;
    exp   = 16'h0000;
    known = 1'b1;
    if (a < 16'h4000) begin
      known = m_ram_v[a[13:0]]; exp = m_ram[a[13:0]];
    end else if (a[15:13] == 3'b010) begin
      known = m_scr_v[a[12:0]]; exp = m_scr[a[12:0]];
    end else if (a == 16'h6000) begin
      known = m_known; exp = (m_kbd.size() > 0) ? m_kbd[0] : 16'h0000;
    end
    if (known) chk("inM", inM, exp);
    if (m_known) begin
      chk("key_ready", {15'b0, key_ready}, 16'(m_kbd.size() < CAP));
      chk("addr_err", {15'b0, addr_err}, {15'b0, m_err});
    end
    if (m_disp_v) chk("disp_data", disp_data, m_disp);
    @(posedge clk);
    if (rst) begin
      m_kbd.delete();
      m_err = 1'b0; m_disp = 16'h0000; m_disp_v = 1'b1; m_known = 1'b1;
    end else begin
      m_disp_v = m_scr_v[da]; m_disp = m_scr[da];
      do_pop  = w && (a == 16'h6000) && (m_kbd.size() > 0);
      do_push = kv && (m_kbd.size() < CAP);
      if (do_pop)  void'(m_kbd.pop_front());
      if (do_push) m_kbd.push_back(kc);
      if (a > 16'h6000) m_err = 1'b1;
      if (w && a < 16'h4000) begin m_ram[a[13:0]] = d; m_ram_v[a[13:0]] = 1'b1; end
      if (w && a[15:13] == 3'b010) begin m_scr[a[12:0]] = d; m_scr_v[a[12:0]] = 1'b1; end
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    step(1'b0, a, d, 1'b1, 1'b0, 16'h0, da_cur, rd);
  endtask

  task automatic rdm(input logic [15:0] a);
    step(1'b0, a, 16'h0, 1'b0, 1'b0, 16'h0, da_cur, rd);
  endtask

  task automatic push(input logic [15:0] kc);
    step(1'b0, 16'h0000, 16'h0, 1'b0, 1'b1, kc, da_cur, rd);
  endtask

  initial begin
    logic [15:0] a;
    @(negedge clk);
    step(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 13'h0, rd);
    step(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 13'h0, rd);
    chk("rst_disp", disp_data, 16'h0000);
    chk("rst_ready", {15'b0, key_ready}, 16'h0001);
    chk("rst_err", {15'b0, addr_err}, 16'h0000);

    for (int i = 0; i < 64; i++) begin
      wr(16'(i), 16'($urandom));
      wr(16'h4000 + 16'(i), (i == 32) ? 16'h0000 : 16'($urandom));
    end

    wr(16'h0005, 16'h1234);
    wr(16'h4010, 16'hBEEF);
    rdm(16'h0005);  chk("ram_1234", rd, 16'h1234);
    rdm(16'h4010);  chk("scr_beef", rd, 16'hBEEF);
    da_cur = 13'h0010;
    rdm(16'h0000);  chk("disp_beef", disp_data, 16'hBEEF);

    push(16'h0041);
    push(16'h0042);
    rdm(16'h6000);  chk("kbd_0041", rd, 16'h0041);
    wr(16'h6000, 16'hFFFF);
    rdm(16'h6000);
`ifdef DATA_MEM_KBD_FIFO_EN
    chk("kbd_0042", rd, 16'h0042);
`else
    chk("kbd_hold_empty", rd, 16'h0000);
`endif
    wr(16'h6000, 16'h0000);
    rdm(16'h6000);  chk("kbd_empty", rd, 16'h0000);
    wr(16'h6000, 16'h0000);
    rdm(16'h6000);  chk("kbd_underflow", rd, 16'h0000);

    for (int i = 0; i < 5; i++) push(16'h0100 + 16'(i));
    chk("full_ready", {15'b0, key_ready}, 16'h0000);
    step(1'b0, 16'h6000, 16'h0, 1'b1, 1'b1, 16'h0200, da_cur, rd);
    for (int i = 0; i < CAP + 1; i++) wr(16'h6000, 16'h0);
    rdm(16'h6000);  chk("drained", rd, 16'h0000);
    step(1'b0, 16'h6000, 16'h0, 1'b1, 1'b1, 16'h0099, da_cur, rd);
    rdm(16'h6000);  chk("push_pop_empty", rd, 16'h0099);
    wr(16'h6000, 16'h0);

    da_cur = 13'h0020;
    rdm(16'h0000);
    step(1'b0, 16'h4020, 16'h5555, 1'b1, 1'b0, 16'h0, da_cur, rd);
    chk("rbw_old", disp_data, 16'h0000);
    rdm(16'h0000);  chk("rbw_new", disp_data, 16'h5555);

    rdm(16'h7000);  chk("unmapped_rd", rd, 16'h0000);
    chk("err_set", {15'b0, addr_err}, 16'h0001);
    rdm(16'h0001);
    wr(16'h6001, 16'hDEAD);
    rdm(16'h0001);
    chk("err_sticky", {15'b0, addr_err}, 16'h0001);
    step(1'b1, 16'h0000, 16'h0, 1'b0, 1'b0, 16'h0, da_cur, rd);
    chk("err_clear", {15'b0, addr_err}, 16'h0000);

    push(16'h0301);
    push(16'h0302);
    step(1'b1, 16'h0000, 16'h0, 1'b0, 1'b1, 16'h0303, da_cur, rd);
    chk("rst_push_ready", {15'b0, key_ready}, 16'h0001);
    rdm(16'h6000);  chk("rst_push_kbd", rd, 16'h0000);
    rdm(16'h0005);  chk("ram_retained", rd, 16'h1234);

    for (int n = 0; n < 2000; n++) begin
      bit rst_r;
      case ($urandom_range(0, 5))
        0, 1:    a = 16'($urandom_range(0, 63));
        2:       a = 16'h4000 + 16'($urandom_range(0, 63));
        3:       a = 16'h6000;
        4:       a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'h6001, 16'hFFFF)) : 16'h6000;
        default: a = 16'h4000 + 16'($urandom_range(0, 63));
      endcase
      rst_r = ($urandom_range(0, 63) == 0);
      step(rst_r, a, 16'($urandom), rst_r ? 1'b0 : 1'($urandom), 1'($urandom), 16'($urandom),
           13'($urandom_range(0, 63)), rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
